alu_arbiter: RTL and testbench

Shares the single combinational `alu` datapath between two requesters: the integer execute stage (port 0) and the multi-cycle helper unit (port 1, used for multiply/divide step sequencing).
Each requester issues operands A, B and a 4-bit ALU control code over a valid/ready channel. At most one request is granted per clock, using round-robin priority. The result, zero flag and overflow flag are registered into a per-requester response slot, which drains over a second valid/ready channel.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu.sv | 72 +++++++
 rtl/alu_rr_arb2.sv | 43 ++++
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU arbiter slice
// Holds the ALU control-code width, the thirteen defined control codes,
// the response-slot record and the round-robin pointer encoding.
package alu_pkg;

  localparam int CTRL_W = 4;
  localparam int ALU_W  = 32;

  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SLE = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SGT = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SGE = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SRA = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_SLL = 4'b1001;
  localparam logic [CTRL_W-1:0] ALU_SRL = 4'b1010;
  localparam logic [CTRL_W-1:0] ALU_SEQ = 4'b1011;
  localparam logic [CTRL_W-1:0] ALU_SNE = 4'b1100;
  localparam logic [CTRL_W-1:0] ALU_AND = 4'b1101;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b1110;

  // One response slot: registered ALU outputs plus occupancy.
  typedef struct packed {
    logic [0:ALU_W-1] result;
    logic             zero;
    logic             of;
    logic             valid;
  } alu_slot_t;

  // Which port wins when both are eligible.
  typedef enum logic {
    PRI_PORT0 = 1'b0,
    PRI_PORT1 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU shared by the arbiter ports
// Ports:
//   a_i, b_i   operands, bit 0 = MSB
//   ctrl_i     control code (see alu_pkg)
//   result_o   result, bit 0 = MSB
//   zero_o     result is all zeros
//   of_o       signed overflow on add/sub, 0 otherwise
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [0:WIDTH-1]  a_i,
  input  logic [0:WIDTH-1]  b_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [0:WIDTH-1]  result_o,
  output logic              zero_o,
  output logic              of_o
);

  localparam int SHW = $clog2(WIDTH);

  // Work in conventional descending order; the port ordering only
  // renames bits, MSB still maps to MSB.
  logic [WIDTH-1:0] ua;
  logic [WIDTH-1:0] ub;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] r;
  logic [SHW-1:0]   shamt;
  logic             lt;
  logic             eq;

  assign ua    = a_i;
  assign ub    = b_i;
  assign sum   = ua + ub;
  assign diff  = ua - ub;
  assign shamt = ub[SHW-1:0];
  assign lt    = $signed(ua) < $signed(ub);
  assign eq    = (ua == ub);

  always_comb begin
    r    = '0;
    of_o = 1'b0;
    case (ctrl_i)
      ALU_ADD: begin
        r    = sum;
        of_o = (ua[WIDTH-1] == ub[WIDTH-1]) && (sum[WIDTH-1] != ua[WIDTH-1]);
      end
      ALU_SUB: begin
        r    = diff;
        of_o = (ua[WIDTH-1] != ub[WIDTH-1]) && (diff[WIDTH-1] != ua[WIDTH-1]);
      end
      ALU_SLT: r[0] = lt;
      ALU_SLE: r[0] = lt | eq;
      ALU_SGT: r[0] = ~(lt | eq);
      ALU_SGE: r[0] = ~lt;
      ALU_SRA: r    = $signed(ua) >>> shamt;
      ALU_SLL: r    = ua << shamt;
      ALU_SRL: r    = ua >> shamt;
      ALU_SEQ: r[0] = eq;
      ALU_SNE: r[0] = ~eq;
      ALU_AND: r    = ua & ub;
      ALU_OR:  r    = ua | ub;
      default: r    = '0;
    endcase
  end

  assign result_o = r;
  assign zero_o   = (r == '0);

endmodule

// File: rtl/alu_rr_arb2.sv
// rtl/alu_rr_arb2.sv - two-way round-robin grant generator
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   eligible_i   per-port eligibility, index 0 = port 0
//   grant_o      one-hot grant, index 0 = port 0 (all zero when idle)
module alu_rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:1] eligible_i,
  output logic [0:1] grant_o
);

  rr_ptr_e ptr_q;
  rr_ptr_e ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PRI_PORT0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    case (eligible_i)
      2'b10:   grant_o = 2'b10;
      2'b01:   grant_o = 2'b01;
      2'b11:   grant_o = (ptr_q == PRI_PORT0) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
    // Priority passes to the loser of every grant, contended or not.
    if (grant_o[0]) begin
      ptr_d = PRI_PORT1;
    end else if (grant_o[1]) begin
      ptr_d = PRI_PORT0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   reqN_valid/ready         request handshake for port N
//   reqN_a, reqN_b, reqN_ctrl  operands and control code for port N
//   rspN_valid/ready         response handshake for port N
//   rspN_result/zero/of      registered ALU outputs for port N
//   grant_cnt0, grant_cnt1   wrapping count of accepted requests per port
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [0:WIDTH-1]  req0_a,
  input  logic [0:WIDTH-1]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [0:WIDTH-1]  rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp0_of,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [0:WIDTH-1]  req1_a,
  input  logic [0:WIDTH-1]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [0:WIDTH-1]  rsp1_result,
  output logic              rsp1_zero,
  output logic              rsp1_of,

  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  alu_slot_t         slot0_q;
  alu_slot_t         slot0_d;
  alu_slot_t         slot1_q;
  alu_slot_t         slot1_d;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt0_d;
  logic [CNT_W-1:0]  cnt1_q;
  logic [CNT_W-1:0]  cnt1_d;

  logic [0:1]        eligible;
  logic [0:1]        grant;
  logic [0:WIDTH-1]  alu_a;
  logic [0:WIDTH-1]  alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [0:WIDTH-1]  alu_result;
  logic              alu_zero;
  logic              alu_of;

  // A port may be granted only if its slot is empty or is being drained
  // this cycle, so a stalled response is never overwritten.
  assign eligible[0] = req0_valid & (~slot0_q.valid | rsp0_ready);
  assign eligible[1] = req1_valid & (~slot1_q.valid | rsp1_ready);

  alu_rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .eligible_i (eligible),
    .grant_o    (grant)
  );

  // Port 0 drives the ALU by default; its idle result is simply not stored.
  always_comb begin
    alu_a    = req0_a;
    alu_b    = req0_b;
    alu_ctrl = req0_ctrl;
    if (grant[1]) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_ctrl = req1_ctrl;
    end
  end

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .ctrl_i   (alu_ctrl),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .of_o     (alu_of)
  );

  // Grant wins over drain, so a same-cycle drain+grant refills with no bubble.
  always_comb begin
    slot0_d = slot0_q;
    if (grant[0]) begin
      slot0_d.result = alu_result;
      slot0_d.zero   = alu_zero;
      slot0_d.of     = alu_of;
      slot0_d.valid  = 1'b1;
    end else if (rsp0_ready) begin
      slot0_d.valid  = 1'b0;
    end
  end

  always_comb begin
    slot1_d = slot1_q;
    if (grant[1]) begin
      slot1_d.result = alu_result;
      slot1_d.zero   = alu_zero;
      slot1_d.of     = alu_of;
      slot1_d.valid  = 1'b1;
    end else if (rsp1_ready) begin
      slot1_d.valid  = 1'b0;
    end
  end

  assign cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, grant[0]};
  assign cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, grant[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];

  assign rsp0_valid  = slot0_q.valid;
  assign rsp0_result = slot0_q.result;
  assign rsp0_zero   = slot0_q.zero;
  assign rsp0_of     = slot0_q.of;

  assign rsp1_valid  = slot1_q.valid;
  assign rsp1_result = slot1_q.result;
  assign rsp1_zero   = slot1_q.zero;
  assign rsp1_of     = slot1_q.of;

  assign grant_cnt0  = cnt0_q;
  assign grant_cnt1  = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int CW   = 4;
  localparam int CMOD = 1 << CW;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -MAXI - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_of;
  logic [31:0] req0_a, req0_b, rsp0_result;
  logic [3:0]  req0_ctrl;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_of;
  logic [31:0] req1_a, req1_b, rsp1_result;
  logic [3:0]  req1_ctrl;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: per-port slot contents, counters and who has priority.
  logic        m_valid [2];
  logic [31:0] m_res   [2];
  logic        m_zero  [2];
  logic        m_of    [2];
  int          m_cnt   [2];
  int          m_ptr;
  logic        g0, g1;

  logic [3:0] codes [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7,
                             4'h9, 4'ha, 4'hb, 4'hc, 4'hd, 4'he};

  alu_arbiter #(.WIDTH(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp0_of(rsp0_of),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .rsp1_of(rsp1_of),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // Returns {of, zero, result} computed with plain signed arithmetic.
  function automatic logic [33:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, s, t;
    logic [31:0] r;
    logic o;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    r = 32'd0;
    o = 1'b0;
    case (c)
      4'h0: begin s = sa + sb; r = s[31:0]; o = (s > MAXI) || (s < MINI); end
      4'h1: begin s = sa - sb; r = s[31:0]; o = (s > MAXI) || (s < MINI); end
      4'h2: r = (sa <  sb) ? 32'd1 : 32'd0;
      4'h3: r = (sa <= sb) ? 32'd1 : 32'd0;
      4'h4: r = (sa >  sb) ? 32'd1 : 32'd0;
      4'h5: r = (sa >= sb) ? 32'd1 : 32'd0;
      4'h7: begin t = sa >>> sh; r = t[31:0]; end
      4'h9: r = a << sh;
      4'ha: r = a >> sh;
      4'hb: r = (a == b) ? 32'd1 : 32'd0;
      4'hc: r = (a != b) ? 32'd1 : 32'd0;
      4'hd: r = a & b;
      4'he: r = a | b;
      default: r = 32'd0;
    endcase
    return {o, (r == 32'd0), r};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_res[i] = 32'd0; m_zero[i] = 1'b0; m_of[i] = 1'b0; m_cnt[i] = 0;
    end
    m_ptr = 0;
  endtask

  // Called just after inputs change at a falling edge.
  task automatic predict();
    logic e0, e1;
    #1;
    e0 = req0_valid && (!m_valid[0] || rsp0_ready);
    e1 = req1_valid && (!m_valid[1] || rsp1_ready);
    if (e0 && e1) begin
      g0 = (m_ptr == 0);
      g1 = (m_ptr == 1);
    end else begin
      g0 = e0;
      g1 = e1;
    end
  endtask

  // Applies the predicted cycle to the model, then clocks the DUT.
  task automatic commit();
    logic [33:0] x;
    if (g0) begin
      x = ref_alu(req0_ctrl, req0_a, req0_b);
      m_res[0] = x[31:0]; m_zero[0] = x[32]; m_of[0] = x[33]; m_valid[0] = 1'b1;
      m_cnt[0] = (m_cnt[0] + 1) % CMOD;
    end else if (rsp0_ready) m_valid[0] = 1'b0;
    if (g1) begin
      x = ref_alu(req1_ctrl, req1_a, req1_b);
      m_res[1] = x[31:0]; m_zero[1] = x[32]; m_of[1] = x[33]; m_valid[1] = 1'b1;
      m_cnt[1] = (m_cnt[1] + 1) % CMOD;
    end else if (rsp1_ready) m_valid[1] = 1'b0;
    if (g0) m_ptr = 1;
    else if (g1) m_ptr = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0; rsp0_ready = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    #1;
    tests_run++;
    if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_of, rsp1_valid, rsp1_result, rsp1_zero,
         rsp1_of, grant_cnt0, grant_cnt1, req0_ready, req1_ready} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got v0=%b r0=%h v1=%b r1=%h c0=%0d c1=%0d, need all zero",
               rsp0_valid, rsp0_result, rsp1_valid, rsp1_result, grant_cnt0, grant_cnt1);
    end
  endtask

  task automatic test_single_port0();
    idle_inputs();
    do_reset();
    req0_valid = 1; req0_a = 32'h00000000; req0_b = 32'h00000001; req0_ctrl = 4'h0;
    predict();
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_ready: got %b%b need 10", req0_ready, req1_ready);
    end
    commit();
    tests_run++;
    if ({rsp0_valid, rsp0_result, rsp0_zero, grant_cnt0} !== {1'b1, 32'h1, 1'b0, 4'd1}) begin
      tests_failed++;
      $display("FAIL single_rsp: got v=%b r=%h z=%b c=%0d need v=1 r=00000001 z=0 c=1",
               rsp0_valid, rsp0_result, rsp0_zero, grant_cnt0);
    end
    req0_valid = 0; rsp0_ready = 1;
    predict();
    commit();
    tests_run++;
    if ({rsp0_valid, rsp0_result} !== {1'b0, 32'h1}) begin
      tests_failed++;
      $display("FAIL single_drain: got v=%b r=%h need v=0 r=00000001", rsp0_valid, rsp0_result);
    end
  endtask

  task automatic test_contention();
    logic exp0;
    idle_inputs();
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_a = 32'h1; req0_b = 32'h1; req0_ctrl = 4'h1;
    req1_valid = 1; req1_a = 32'h10101010; req1_b = 32'h4; req1_ctrl = 4'h9;
    for (int i = 0; i < 4; i++) begin
      exp0 = (i % 2 == 0);
      predict();
      tests_run++;
      if ({req0_ready, req1_ready} !== {exp0, !exp0}) begin
        tests_failed++;
        $display("FAIL contention_grant%0d: got %b%b need %b%b", i, req0_ready, req1_ready,
                 exp0, !exp0);
      end
      commit();
      tests_run++;
      if (exp0 && {rsp0_valid, rsp0_result, rsp0_zero} !== {1'b1, 32'h0, 1'b1}) begin
        tests_failed++;
        $display("FAIL contention_rsp0_%0d: got v=%b r=%h z=%b need 1 00000000 1", i,
                 rsp0_valid, rsp0_result, rsp0_zero);
      end else if (!exp0 && {rsp1_valid, rsp1_result, rsp1_zero} !== {1'b1, 32'h01010100, 1'b0}) begin
        tests_failed++;
        $display("FAIL contention_rsp1_%0d: got v=%b r=%h z=%b need 1 01010100 0", i,
                 rsp1_valid, rsp1_result, rsp1_zero);
      end
    end
    tests_run++;
    if ({grant_cnt0, grant_cnt1} !== {4'd2, 4'd2}) begin
      tests_failed++;
      $display("FAIL contention_cnt: got %0d/%0d need 2/2", grant_cnt0, grant_cnt1);
    end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    do_reset();
    rsp1_ready = 1;
    req0_valid = 1; req0_a = 32'h2; req0_b = 32'h3; req0_ctrl = 4'h0;
    predict();
    commit();
    req0_a = 32'h10; req0_b = 32'h1;
    req1_valid = 1; req1_a = 32'hf0101010; req1_b = 32'h4; req1_ctrl = 4'ha;
    for (int i = 0; i < 3; i++) begin
      predict();
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        tests_failed++;
        $display("FAIL bp_grant%0d: got %b%b need 01", i, req0_ready, req1_ready);
      end
      commit();
      tests_run++;
      if ({rsp0_valid, rsp0_result, rsp1_valid, rsp1_result} !==
          {1'b1, 32'h5, 1'b1, 32'h0f010101}) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got r0=%h v0=%b r1=%h v1=%b need r0=00000005 r1=0f010101",
                 i, rsp0_result, rsp0_valid, rsp1_result, rsp1_valid);
      end
    end
    rsp0_ready = 1;
    predict();
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL bp_release: got %b%b need 10", req0_ready, req1_ready);
    end
    commit();
    tests_run++;
    if ({rsp0_valid, rsp0_result} !== {1'b1, 32'h11}) begin
      tests_failed++;
      $display("FAIL bp_refill: got v=%b r=%h need 1 00000011", rsp0_valid, rsp0_result);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    do_reset();
    rsp0_ready = 1;
    req0_valid = 1; req0_a = 32'h01010101; req0_b = 32'hffffffff; req0_ctrl = 4'hd;
    for (int i = 0; i < 5; i++) begin
      predict();
      commit();
      tests_run++;
      if ({rsp0_valid, rsp0_result} !== {1'b1, 32'h01010101}) begin
        tests_failed++;
        $display("FAIL b2b_rsp%0d: got v=%b r=%h need 1 01010101", i, rsp0_valid, rsp0_result);
      end
    end
    tests_run++;
    if (grant_cnt0 !== 4'd5) begin
      tests_failed++;
      $display("FAIL b2b_cnt: got %0d need 5", grant_cnt0);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    do_reset();
    rsp0_ready = 1;
    req0_valid = 1; req0_a = 32'h7; req0_b = 32'h1; req0_ctrl = 4'h0;
    req1_valid = 1; req1_a = 32'h9; req1_b = 32'h2; req1_ctrl = 4'he;
    predict(); commit();
    predict(); commit();
    tests_run++;
    if (rsp1_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_setup: got rsp1_valid=%b need 1", rsp1_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({rsp0_valid, rsp1_valid, grant_cnt0, grant_cnt1} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_async: got v0=%b v1=%b c0=%0d c1=%0d need all zero",
               rsp0_valid, rsp1_valid, grant_cnt0, grant_cnt1);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    predict();
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL midrst_first: got %b%b need 10", req0_ready, req1_ready);
    end
    commit();
  endtask

  task automatic test_counter_wrap();
    idle_inputs();
    do_reset();
    rsp1_ready = 1;
    req1_valid = 1; req1_a = 32'h3; req1_b = 32'h4; req1_ctrl = 4'h0;
    for (int i = 0; i < 17; i++) begin
      predict();
      commit();
    end
    tests_run++;
    if ({grant_cnt1, grant_cnt0} !== {4'd1, 4'd0}) begin
      tests_failed++;
      $display("FAIL cnt_wrap: got c1=%0d c0=%0d need 1/0", grant_cnt1, grant_cnt0);
    end
  endtask

  task automatic test_random();
    int errs;
    idle_inputs();
    do_reset();
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      req0_ctrl = codes[$urandom_range(0, 12)];
      req1_ctrl = codes[$urandom_range(0, 12)];
      predict();
      tests_run++;
      if ({req0_ready, req1_ready} !== {g0, g1}) begin
        tests_failed++;
        $display("FAIL rand_grant@%0d: got %b%b need %b%b", i, req0_ready, req1_ready, g0, g1);
      end
      commit();
      tests_run++;
      if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_of, rsp1_valid, rsp1_result, rsp1_zero,
           rsp1_of, grant_cnt0, grant_cnt1} !==
          {m_valid[0], m_res[0], m_zero[0], m_of[0], m_valid[1], m_res[1], m_zero[1], m_of[1],
           CW'(m_cnt[0]), CW'(m_cnt[1])}) begin
        tests_failed++;
        if (errs < 10)
          $display("FAIL rand_rsp@%0d: got %b/%h/%b%b %b/%h/%b%b c%0d/%0d need %b/%h/%b%b %b/%h/%b%b c%0d/%0d",
                   i, rsp0_valid, rsp0_result, rsp0_zero, rsp0_of, rsp1_valid, rsp1_result,
                   rsp1_zero, rsp1_of, grant_cnt0, grant_cnt1, m_valid[0], m_res[0], m_zero[0],
                   m_of[0], m_valid[1], m_res[1], m_zero[1], m_of[1], m_cnt[0], m_cnt[1]);
        errs++;
      end
    end
  endtask

  initial begin
    idle_inputs();
    model_clear();
    test_reset();
    test_single_port0();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
